// File: rtl/demux_dispatch_pkg.sv
// Shared constants, port index type and round-robin helper for the 5-way dispatcher.
package demux_pkg;
  localparam int NUM_PORTS = 5;
  localparam int DEST_W    = 3;
  localparam logic [DEST_W-1:0] DEST_ANY = 3'd7;

  typedef logic [DEST_W-1:0] port_idx_t;

  function automatic port_idx_t rr_next(port_idx_t idx);
    return (idx == port_idx_t'(NUM_PORTS - 1)) ? '0 : idx + 1'b1;
  endfunction
endpackage

// File: rtl/demux_dispatch_if.sv
// Upstream stream plus five consumer ports of demux_dispatch; slave = dispatcher side.
interface demux_dispatch_if #(
  parameter int DATA_W = 16,
  parameter int STAT_W = 16
);
  import demux_pkg::*;

  logic                        in_valid;
  logic [DEST_W-1:0]           in_dest;
  logic [DATA_W-1:0]           in_data;
  logic                        in_ready;
  logic [NUM_PORTS-1:0]        out_valid;
  logic [NUM_PORTS-1:0]        out_ready;
  logic [DATA_W-1:0]           data_out_0;
  logic [DATA_W-1:0]           data_out_1;
  logic [DATA_W-1:0]           data_out_2;
  logic [DATA_W-1:0]           data_out_3;
  logic [DATA_W-1:0]           data_out_4;
  port_idx_t                   out_port;
  logic                        err_drop;
  logic [STAT_W-1:0]           stall_cnt;

  modport slave (
    input  in_valid, in_dest, in_data, out_ready,
    output in_ready, out_valid, data_out_0, data_out_1, data_out_2, data_out_3, data_out_4,
           out_port, err_drop, stall_cnt
  );

  modport master (
    output in_valid, in_dest, in_data, out_ready,
    input  in_ready, out_valid, data_out_0, data_out_1, data_out_2, data_out_3, data_out_4,
           out_port, err_drop, stall_cnt
  );
endinterface

// File: rtl/demux_dispatch_slot.sv
// One-entry holding register; a load wins over a drain so a draining slot refills without a bubble.
module demux_slot #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic [DATA_W-1:0] din,
  input  logic              drain,
  output logic              valid,
  output logic [DATA_W-1:0] dout
);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid <= 1'b0;
      dout  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      dout  <= din;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/demux_dispatch.sv
// One-in, five-out stream distributor with fixed, round-robin "any" and illegal destinations.
// Optional saturating stall counter enabled by DEMUX_STATS_EN.
module demux_dispatch
  import demux_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int STAT_W = 16
) (
  input logic         clk,
  input logic         reset_n,
  demux_dispatch_if.slave bus
);
  logic [NUM_PORTS-1:0]             free, dest_oh, cand_oh, load, vld;
  logic [NUM_PORTS-1:0][DATA_W-1:0] dq;
  port_idx_t                        rr_ptr, cand, p, tgt;
  logic                             is_fixed, is_any, is_ill, found, rdy, accept;

  // in_ready depends only on in_dest, slot state and out_ready, never on in_valid
  always_comb begin
    is_fixed = bus.in_dest < DEST_W'(NUM_PORTS);
    is_any   = bus.in_dest == DEST_ANY;
    is_ill   = !is_fixed && !is_any;
    free     = ~vld | bus.out_ready;
    for (int i = 0; i < NUM_PORTS; i++) dest_oh[i] = bus.in_dest == DEST_W'(i);

    cand  = '0;
    found = 1'b0;
    p     = rr_ptr;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (!found && free[p]) begin
        cand  = p;
        found = 1'b1;
      end
      p = rr_next(p);
    end
    for (int i = 0; i < NUM_PORTS; i++) cand_oh[i] = found && (cand == DEST_W'(i));

    if (is_fixed)    rdy = |(dest_oh & free);
    else if (is_any) rdy = found;
    else             rdy = 1'b1;

    accept = bus.in_valid && rdy;
    tgt    = is_any ? cand : bus.in_dest;
    load   = '0;
    if (accept && is_fixed)    load = dest_oh;
    else if (accept && is_any) load = cand_oh;
  end

  assign bus.in_ready = rdy;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr       <= '0;
      bus.out_port <= '0;
      bus.err_drop <= 1'b0;
    end else begin
      bus.err_drop <= accept && is_ill;
      if (accept && !is_ill) bus.out_port <= tgt;
      if (accept && is_any)  rr_ptr       <= rr_next(cand);
    end
  end

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_slot
    demux_slot #(.DATA_W(DATA_W)) u_slot (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (load[i]),
      .din     (bus.in_data),
      .drain   (bus.out_ready[i]),
      .valid   (vld[i]),
      .dout    (dq[i])
    );
  end

  assign bus.out_valid  = vld;
  assign bus.data_out_0 = dq[0];
  assign bus.data_out_1 = dq[1];
  assign bus.data_out_2 = dq[2];
  assign bus.data_out_3 = dq[3];
  assign bus.data_out_4 = dq[4];

`ifdef DEMUX_STATS_EN
  logic [STAT_W-1:0] stall_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                      stall_q <= '0;
    else if (bus.in_valid && !rdy && stall_q != '1)    stall_q <= stall_q + 1'b1;
  end

  assign bus.stall_cnt = stall_q;
`else
  assign bus.stall_cnt = '0;
`endif
endmodule

// File: tb/tb_demux_dispatch.sv
// Directed plus random bench for demux_dispatch against a queue-free slot/pointer reference model.
module tb_demux_dispatch;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  demux_dispatch_if #(.DATA_W(16), .STAT_W(16)) bus();

  demux_dispatch #(.DATA_W(16), .STAT_W(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  bit          m_vld [5];
  logic [15:0] m_dat [5];
  int          m_port, m_rr, m_stall;
  bit          m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] get_dout(input int i);
    case (i)
      0:       return bus.data_out_0;
      1:       return bus.data_out_1;
      2:       return bus.data_out_2;
      3:       return bus.data_out_3;
      default: return bus.data_out_4;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 5; i++) begin
      m_vld[i] = 1'b0;
      m_dat[i] = '0;
    end
    m_port = 0; m_rr = 0; m_stall = 0; m_err = 1'b0;
  endtask

  function automatic bit m_free(input int i);
    return !m_vld[i] || bus.out_ready[i];
  endfunction

  // port the current word would go to, or -1 if none
  function automatic int m_target();
    int d = int'(bus.in_dest);
    if (d < 5) return d;
    if (d == 7) begin
      for (int k = 0; k < 5; k++)
        if (m_free((m_rr + k) % 5)) return (m_rr + k) % 5;
    end
    return -1;
  endfunction

  function automatic bit m_ready();
    int d = int'(bus.in_dest);
    if (d < 5)  return m_free(d);
    if (d == 7) return m_target() >= 0;
    return 1'b1;
  endfunction

  task automatic check_outputs(input string tag);
    logic [4:0] ev;
    for (int i = 0; i < 5; i++) ev[i] = m_vld[i];
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(ev));
    for (int i = 0; i < 5; i++)
      chk($sformatf("%s.data_out_%0d", tag, i), 32'(get_dout(i)), 32'(m_dat[i]));
    chk({tag, ".out_port"},  32'(bus.out_port),  32'(m_port));
    chk({tag, ".err_drop"},  32'(bus.err_drop),  32'(m_err));
    chk({tag, ".stall_cnt"}, 32'(bus.stall_cnt), 32'(m_stall));
  endtask

  task automatic step(input string tag, input logic v, input logic [2:0] d,
                      input logic [15:0] data, input logic [4:0] rdy);
    bit exp_rdy, acc;
    int tgt;
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_dest   = d;
    bus.in_data   = data;
    bus.out_ready = rdy;
    #1;
    exp_rdy = m_ready();
    chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'(exp_rdy));
    tgt = m_target();
    acc = v && exp_rdy;
`ifdef DEMUX_STATS_EN
    if (v && !exp_rdy && m_stall < 65535) m_stall++;
`endif
    m_err = acc && (d == 3'd5 || d == 3'd6);
    for (int i = 0; i < 5; i++) if (rdy[i]) m_vld[i] = 1'b0;
    if (acc && tgt >= 0) begin
      m_vld[tgt] = 1'b1;
      m_dat[tgt] = data;
      m_port     = tgt;
      if (d == 3'd7) m_rr = (tgt + 1) % 5;
    end
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 3'd0, 16'h0, 5'b0);
  endtask

  // reset asserted between edges: slots must clear without waiting for a clock
  task automatic pulse_reset(input string tag);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = '0;
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs({tag, ".async"});
    @(posedge clk);
    #1;
    check_outputs({tag, ".held"});
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_dest   = '0;
    bus.in_data   = '0;
    bus.out_ready = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // 1: fixed dest fills port 2; second word to port 2 blocks
    step("t1a", 1'b1, 3'd2, 16'hA5A5, 5'b00000);
    chk("t1.out_valid", 32'(bus.out_valid), 32'h04);
    chk("t1.data2", 32'(bus.data_out_2), 32'hA5A5);
    chk("t1.port", 32'(bus.out_port), 32'd2);
    step("t1b", 1'b1, 3'd2, 16'h5555, 5'b00000);
    chk("t1b.data2_kept", 32'(bus.data_out_2), 32'hA5A5);

    // 2: drain and refill in the same cycle
    step("t2", 1'b1, 3'd2, 16'h1234, 5'b00100);
    chk("t2.valid2", 32'(bus.out_valid[2]), 32'd1);
    chk("t2.data2", 32'(bus.data_out_2), 32'h1234);

    // 3: any-dest fills 0..4 in order, then stalls
    pulse_reset("t3rst");
    for (int k = 0; k < 5; k++) begin
      step("t3fill", 1'b1, 3'd7, 16'hC000 + 16'(k), 5'b00000);
      chk("t3.port_order", 32'(bus.out_port), 32'(k));
    end
    chk("t3.all_full", 32'(bus.out_valid), 32'h1F);
    step("t3stall1", 1'b1, 3'd7, 16'hC005, 5'b00000);
    step("t3stall2", 1'b1, 3'd7, 16'hC006, 5'b00000);

    // 4: rr_ptr=3, ports 3,4 full, 0..2 free -> port 0, then pointer at 1
    pulse_reset("t4rst");
    for (int k = 0; k < 3; k++) step("t4fill", 1'b1, 3'd7, 16'hD000 + 16'(k), 5'b00000);
    step("t4p3", 1'b1, 3'd3, 16'hD003, 5'b00000);
    step("t4p4", 1'b1, 3'd4, 16'hD004, 5'b00000);
    step("t4drain", 1'b0, 3'd0, 16'h0, 5'b00111);
    step("t4any", 1'b1, 3'd7, 16'hBEEF, 5'b00000);
    chk("t4.port", 32'(bus.out_port), 32'd0);
    chk("t4.data0", 32'(bus.data_out_0), 32'hBEEF);
    step("t4next", 1'b1, 3'd7, 16'hBEF0, 5'b00000);
    chk("t4.rr_next_port", 32'(bus.out_port), 32'd1);

    // 5: illegal dest drops with one-cycle err pulse
    step("t5", 1'b1, 3'd5, 16'hDEAD, 5'b00000);
    chk("t5.err", 32'(bus.err_drop), 32'd1);
    chk("t5.out_valid", 32'(bus.out_valid), 32'h1B);
    idle("t5idle");
    chk("t5.err_clear", 32'(bus.err_drop), 32'd0);
    step("t5b", 1'b1, 3'd6, 16'hDEAF, 5'b11111);

    // 6: reset mid-cycle with ports 0,1 full, then any-dest restarts at 0
    pulse_reset("t6rst");
    step("t6a", 1'b1, 3'd0, 16'hE000, 5'b00000);
    step("t6b", 1'b1, 3'd1, 16'hE001, 5'b00000);
    pulse_reset("t6rst2");
    step("t6any", 1'b1, 3'd7, 16'hE002, 5'b00000);
    chk("t6.port", 32'(bus.out_port), 32'd0);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      if (n % 150 == 149) pulse_reset("rndrst");
      step("rnd", 1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
           16'($urandom), 5'($urandom));
    end
    idle("end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
